// File: rtl/experiment_pkg.sv
// Shared types for the experiment responder: FSM states, error codes and the
// width of the latency/timeout counters.
package experiment_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FG_DELAY   = 3'd1,
    S_FG_HOLD    = 3'd2,
    S_WIRE_DELAY = 3'd3,
    S_WIRE_PULSE = 3'd4,
    S_DET_WAIT   = 3'd5,
    S_DONE       = 3'd6,
    S_ERROR      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK                 = 2'd0,
    ERR_DETONATION_TIMEOUT = 2'd1,
    ERR_DETECTOR_TIMEOUT   = 2'd2,
    ERR_PROTOCOL           = 2'd3
  } err_e;

  // Latency counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/experiment_responder_rise_detect.sv
// Rising-edge detector: one delay flop plus AND; the flop clears to 0 on reset.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/experiment_responder.sv
// Plant-side emulator answering the experiment sequencer's timing lines.
// Optional latency counters are built when EXPERIMENT_RESPONDER_LATENCY_EN is defined.
module experiment_responder
  import experiment_pkg::*;
#(
  parameter int FG_READY_DELAY = 1000,
  parameter int WIRE_DELAY     = 200,
  parameter int PULSE_WIDTH    = 4,
  parameter int TIMEOUT        = 1_000_000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             detonation_signal,
  input  logic             detector_signal,
  output logic             fg_signal,
  output logic             wire_signal,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] fg_to_det,
  output logic [CNT_W-1:0] wire_to_det
);

  localparam logic [CNT_W-1:0] FG_LAST    = CNT_W'(FG_READY_DELAY - 1);
  localparam logic [CNT_W-1:0] WIRE_LAST  = CNT_W'(WIRE_DELAY - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

  logic deton_rise;
  logic det_rise;

  rise_detect u_deton_rise (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_in  (detonation_signal),
    .rise    (deton_rise)
  );

  rise_detect u_det_rise (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_in  (detector_signal),
    .rise    (det_rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fg_q, fg_d;
  logic             wire_q, wire_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  err_e             err_q, err_d;

  // cnt_q is reused per phase; from wire rise it keeps running through
  // WIRE_PULSE into DET_WAIT so it doubles as the detector timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fg_d    = fg_q;
    wire_d  = wire_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          if (detonation_signal || detector_signal) begin
            err_d  = ERR_PROTOCOL;
            done_d = 1'b1;
          end else begin
            err_d   = ERR_OK;
            cnt_d   = '0;
            state_d = S_FG_DELAY;
          end
        end
      end

      S_FG_DELAY: begin
        if (det_rise) begin
          err_d   = ERR_PROTOCOL;
          state_d = S_ERROR;
        end else if (cnt_q == FG_LAST) begin
          fg_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_FG_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FG_HOLD: begin
        // A detector edge here, alone or together with detonation, is early.
        if (det_rise) begin
          err_d   = ERR_PROTOCOL;
          state_d = S_ERROR;
        end else if (deton_rise) begin
          fg_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WIRE_DELAY;
        end else if (cnt_q >= TMO_LAST) begin
          err_d   = ERR_DETONATION_TIMEOUT;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WIRE_DELAY: begin
        if (det_rise || deton_rise) begin
          err_d   = ERR_PROTOCOL;
          state_d = S_ERROR;
        end else if (cnt_q == WIRE_LAST) begin
          wire_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WIRE_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WIRE_PULSE: begin
        if (deton_rise) begin
          err_d   = ERR_PROTOCOL;
          state_d = S_ERROR;
        end else if (det_rise) begin
          state_d = S_DONE;
        end else if (cnt_q >= TMO_LAST) begin
          err_d   = ERR_DETECTOR_TIMEOUT;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PULSE_LAST) begin
            wire_d  = 1'b0;
            state_d = S_DET_WAIT;
          end
        end
      end

      S_DET_WAIT: begin
        if (deton_rise) begin
          err_d   = ERR_PROTOCOL;
          state_d = S_ERROR;
        end else if (det_rise) begin
          state_d = S_DONE;
        end else if (cnt_q >= TMO_LAST) begin
          err_d   = ERR_DETECTOR_TIMEOUT;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_ERROR: begin
        done_d  = 1'b1;
        fg_d    = 1'b0;
        wire_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fg_q    <= 1'b0;
      wire_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fg_q    <= fg_d;
      wire_q  <= wire_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fg_signal   = fg_q;
  assign wire_signal = wire_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error_code  = err_q;

`ifdef EXPERIMENT_RESPONDER_LATENCY_EN
  logic [CNT_W-1:0] fg_to_det_q, fg_to_det_d;
  logic [CNT_W-1:0] wire_to_det_q, wire_to_det_d;
  logic             arm_accept;

  assign arm_accept = (state_q == S_IDLE) && arm && !detonation_signal && !detector_signal;

  // Each counter includes the edge on which the awaited input edge is seen.
  always_comb begin
    fg_to_det_d   = fg_to_det_q;
    wire_to_det_d = wire_to_det_q;
    if (arm_accept) begin
      fg_to_det_d   = '0;
      wire_to_det_d = '0;
    end else if (state_q == S_FG_HOLD) begin
      fg_to_det_d = sat_inc(fg_to_det_q);
    end else if ((state_q == S_WIRE_PULSE) || (state_q == S_DET_WAIT)) begin
      wire_to_det_d = sat_inc(wire_to_det_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fg_to_det_q   <= '0;
      wire_to_det_q <= '0;
    end else begin
      fg_to_det_q   <= fg_to_det_d;
      wire_to_det_q <= wire_to_det_d;
    end
  end

  assign fg_to_det   = fg_to_det_q;
  assign wire_to_det = wire_to_det_q;
`else
  assign fg_to_det   = '0;
  assign wire_to_det = '0;
`endif

endmodule

// File: doc/experiment_responder.md
# experiment_responder

- Plant-side emulator for the experiment sequencer; sits on the bench/loopback side of the experiment timing lines.
- Answers the sequencer's control lines:
  - raises `fg_signal` a programmable time after a run is armed;
  - returns a `wire_signal` pulse a programmable time after the detonation edge;
  - checks that the detector edge follows.
- Measures round-trip latencies and flags protocol violations and timeouts, so the sequencer can be validated in closed loop without field hardware.

## Interface
Parameters:
- `FG_READY_DELAY`, 1000: cycles from arm to `fg_signal` rise (≥1)
- `WIRE_DELAY`, 200: cycles from detonation edge detection to `wire_signal` rise (≥1)
- `PULSE_WIDTH`, 4: `wire_signal` high time in cycles (≥1)
- `TIMEOUT`, 1_000_000: maximum wait for detonation or detector edge

Ports:
- `clock` in 1: system clock. One clock; reset is synchronous and active-low.
- `reset_n` in 1: synchronous, active-low reset
- `arm` in 1: start a run; sampled only in IDLE
- `detonation_signal` in 1: level from sequencer; only its rising edge is significant
- `detector_signal` in 1: level from sequencer; only its rising edge is significant
- `fg_signal` out 1: function-generator ready level
- `wire_signal` out 1: wire-break pulse
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at run end (success or error)
- `error_code` out 2: 0 ok, 1 detonation timeout, 2 detector timeout, 3 protocol violation; held until next accepted arm
- `fg_to_det` out 32: cycles from `fg_signal` rise to detonation edge detection
- `wire_to_det` out 32: cycles from `wire_signal` rise to detector edge detection

## Operation
- All outputs are registered; reset value of every output is 0. State is IDLE after reset.
- Edge detect: one delay flop per input. A rising edge is `in & ~prev`. Both prev flops clear to 0 on reset.
- State machine:
  - IDLE:
    - On `arm`: if `detonation_signal` or `detector_signal` is already high, set `error_code`=3, pulse `done`, stay in IDLE.
    - Otherwise clear `error_code` and the latency outputs, then go to FG_DELAY.
  - FG_DELAY: count to `FG_READY_DELAY`, then set `fg_signal` and go to FG_HOLD.
  - FG_HOLD:
    - `fg_signal` stays high and `fg_to_det` increments.
    - Detonation edge: clear `fg_signal`, go to WIRE_DELAY.
    - No edge within `TIMEOUT` cycles: go to ERROR with code 1.
  - WIRE_DELAY: count `WIRE_DELAY`, then set `wire_signal` and go to WIRE_PULSE.
  - WIRE_PULSE: hold for `PULSE_WIDTH` cycles, clear `wire_signal`, go to DET_WAIT.
  - DET_WAIT:
    - Detector edge: go to DONE.
    - No edge within `TIMEOUT` cycles of wire rise: go to ERROR with code 2.
  - DONE / ERROR: pulse `done` for one cycle, drive `fg_signal` and `wire_signal` to 0, return to IDLE.
- Protocol violation (code 3), from any busy state:
  - detector edge before `wire_signal` rise;
  - a second detonation edge after the first.
- `wire_to_det` counts from the `wire_signal` rise through WIRE_PULSE and DET_WAIT.
- Both latency counters saturate at 2^32−1.
- `arm` while busy is ignored.
- Simultaneous detonation and detector edges in FG_HOLD: protocol violation (code 3).
- `reset_n` low mid-run: returns to IDLE with all outputs 0 on that edge; no `done` pulse.

## Timing
- `arm` sampled high at edge k: `busy` is high after edge k; `fg_signal` rises after edge k+`FG_READY_DELAY`.
- Detonation input rises before edge j:
  - edge detected at edge j;
  - `fg_signal` falls after edge j;
  - `wire_signal` rises after edge j+`WIRE_DELAY` and falls `PULSE_WIDTH` cycles later.
- Detector edge detected at edge m: `done` is high for the cycle after edge m+1; `busy` falls the same cycle.
- Latency fields are stable from the `done` pulse until the next accepted arm.

## Configuration
- `EXPERIMENT_RESPONDER_LATENCY_EN` defined: latency counters are built; `fg_to_det` and `wire_to_det` behave as specified.
- Not defined: counters are not synthesized, both outputs are tied to 0, and error detection is unchanged.

## Structure
- Package `experiment_pkg`:
  - responder state enum (IDLE, FG_DELAY, FG_HOLD, WIRE_DELAY, WIRE_PULSE, DET_WAIT, DONE, ERROR);
  - `error_code` enum;
  - localparam for the 32-bit counter width.
- Sub-module `rise_detect`: one flop plus AND, reset to 0. Instantiated for `detonation_signal` and for `detector_signal`.

## Test plan
Bench parameters: `FG_READY_DELAY`=10, `WIRE_DELAY`=8, `PULSE_WIDTH`=4, `TIMEOUT`=100.
- Nominal run: arm at edge 0, detonation edge 20 cycles after `fg_signal` rise, detector edge 6 cycles after wire rise. Expect `fg_signal` rise at edge 10, `wire_signal` high for 4 cycles starting 8 after detection, `error_code`=0, `fg_to_det`=20, `wire_to_det`=6, one `done` pulse.
- No detonation: arm, then hold `detonation_signal` low. Expect `error_code`=1 and `done` 100 cycles after `fg_signal` rise; `fg_signal` returns to 0.
- No detector: complete the wire pulse, hold `detector_signal` low. Expect `error_code`=2 and `done` after 100 cycles.
- Stale input: `detonation_signal` already high when arm is sampled. Expect immediate `done`, `error_code`=3, `busy` never rises.
- Early detector: detector edge during WIRE_DELAY. Expect `error_code`=3, `wire_signal` never rises.
- Reset mid-run: `reset_n` low during WIRE_PULSE. Expect all outputs 0 next cycle and no `done`; a fresh arm then completes the nominal run.
